// File: rtl/trex_motion_if.sv
// Controller-side bundle for the T-rex motion block: game inputs in, sprite and
// hitbox information out.
interface trex_motion_if #(
    parameter int POS_W   = 10,
    parameter int SPEED_W = 4
);
    logic               tick;
    logic [SPEED_W-1:0] speed;
    logic               jump;
    logic               duck;
    logic               crash;
    logic               restart;
    logic [POS_W-1:0]   x_pos;
    logic [POS_W-1:0]   y_pos;
    logic [POS_W-1:0]   hit_w;
    logic [POS_W-1:0]   hit_h;
    logic [2:0]         frame;
    logic [2:0]         state;
    logic               airborne;

    modport master (
        output tick, speed, jump, duck, crash, restart,
        input  x_pos, y_pos, hit_w, hit_h, frame, state, airborne
    );

    modport slave (
        input  tick, speed, jump, duck, crash, restart,
        output x_pos, y_pos, hit_w, hit_h, frame, state, airborne
    );
endinterface

// File: rtl/trex_motion.sv
// T-rex character controller: state machine, frame-tick jump physics with fractional
// gravity, ducking, speed-drop, jump release and crash/restart, plus animation frame.
module trex_motion #(
    parameter int POS_W        = 10,
    parameter int VEL_W        = 8,
    parameter int SPEED_W      = 4,
    parameter int START_X      = 50,
    parameter int GROUND_Y     = 93,
    parameter int MIN_JUMP_Y   = 63,
    parameter int MAX_JUMP_Y   = 30,
    parameter int INIT_VEL     = -10,
    parameter int SPEED_SHIFT  = 3,
    parameter int DROP_VEL     = -5,
    parameter int SPEED_DROP_V = 8,
    parameter int GRAV_NUM     = 6,
    parameter int GRAV_DEN     = 10,
    parameter int HEIGHT       = 47,
    parameter int WIDTH        = 44,
    parameter int HEIGHT_DUCK  = 25,
    parameter int WIDTH_DUCK   = 59,
    parameter int RUN_TICKS    = 5,
    parameter int DUCK_TICKS   = 10,
    parameter int BLINK_TICKS  = 30
) (
    input  logic           clk,
    input  logic           rst_n,
    trex_motion_if.slave   bus
);

    localparam logic [2:0] ST_WAIT  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_JUMP  = 3'd2;
    localparam logic [2:0] ST_DUCK  = 3'd3;
    localparam logic [2:0] ST_CRASH = 3'd4;

    localparam logic [2:0] FR_WAIT0  = 3'd0;
    localparam logic [2:0] FR_WAIT1  = 3'd1;
    localparam logic [2:0] FR_RUN0   = 3'd2;
    localparam logic [2:0] FR_RUN1   = 3'd3;
    localparam logic [2:0] FR_JUMP0  = 3'd4;
    localparam logic [2:0] FR_DUCK0  = 3'd5;
    localparam logic [2:0] FR_DUCK1  = 3'd6;
    localparam logic [2:0] FR_CRASH0 = 3'd7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int ANIM_W = $clog2(2 * max3(RUN_TICKS, DUCK_TICKS, BLINK_TICKS));
    localparam int ACC_W  = $clog2(GRAV_NUM + GRAV_DEN) + 1;
    // Two spare bits so y + vel can go negative or past the ground without wrapping.
    localparam int YX_W   = POS_W + 2;

    localparam logic [POS_W-1:0]        GROUND_U = POS_W'(GROUND_Y);
    localparam logic [POS_W-1:0]        DUCK_Y_U = POS_W'(GROUND_Y + HEIGHT - HEIGHT_DUCK);
    localparam logic [POS_W-1:0]        MIN_Y_U  = POS_W'(MIN_JUMP_Y);
    localparam logic [POS_W-1:0]        MAX_Y_U  = POS_W'(MAX_JUMP_Y);
    localparam logic signed [YX_W-1:0]  GROUND_S = YX_W'(GROUND_Y);
    localparam logic signed [VEL_W-1:0] INIT_S   = VEL_W'(INIT_VEL);
    localparam logic signed [VEL_W-1:0] DROP_S   = VEL_W'(DROP_VEL);
    localparam logic signed [VEL_W-1:0] SDROP_S  = VEL_W'(SPEED_DROP_V);

    logic [2:0]              state_q, state_d;
    logic [POS_W-1:0]        y_q, y_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    min_q, min_d;
    logic [ANIM_W-1:0]       anim_q, anim_d;
    logic [2:0]              frame_q, frame_d;

    function automatic logic [ANIM_W-1:0] half_period(input logic [2:0] st);
        case (st)
            ST_WAIT: return ANIM_W'(BLINK_TICKS);
            ST_RUN:  return ANIM_W'(RUN_TICKS);
            ST_DUCK: return ANIM_W'(DUCK_TICKS);
            default: return ANIM_W'(1);
        endcase
    endfunction

    function automatic logic [ANIM_W-1:0] anim_last(input logic [2:0] st);
        case (st)
            ST_WAIT: return ANIM_W'(2 * BLINK_TICKS - 1);
            ST_RUN:  return ANIM_W'(2 * RUN_TICKS - 1);
            ST_DUCK: return ANIM_W'(2 * DUCK_TICKS - 1);
            default: return ANIM_W'(1);
        endcase
    endfunction

    function automatic logic [2:0] frame_of(input logic [2:0] st, input logic [ANIM_W-1:0] an);
        logic first_half;
        first_half = (an < half_period(st));
        case (st)
            ST_WAIT: return first_half ? FR_WAIT0 : FR_WAIT1;
            ST_RUN:  return first_half ? FR_RUN0 : FR_RUN1;
            ST_DUCK: return first_half ? FR_DUCK0 : FR_DUCK1;
            ST_JUMP: return FR_JUMP0;
            default: return FR_CRASH0;
        endcase
    endfunction

    logic signed [YX_W-1:0]  y_ext, vel_ext, y_sum;
    logic [POS_W-1:0]        y_air;
    logic                    land;
    logic [ACC_W-1:0]        acc_sum, acc_air;
    logic                    grav;
    logic signed [VEL_W-1:0] vel_g, vel_air, vel_start;
    logic [SPEED_W-1:0]      spd_shift;
    logic                    min_hit;
    logic                    active;

    always_comb begin
        y_ext     = {2'b00, y_q};
        vel_ext   = {{(YX_W-VEL_W){vel_q[VEL_W-1]}}, vel_q};
        y_sum     = y_ext + vel_ext;
        y_air     = y_sum[YX_W-1] ? '0 : y_sum[POS_W-1:0];
        land      = (y_sum >= GROUND_S);
        acc_sum   = acc_q + ACC_W'(GRAV_NUM);
        grav      = (acc_sum >= ACC_W'(GRAV_DEN));
        acc_air   = grav ? acc_sum - ACC_W'(GRAV_DEN) : acc_sum;
        vel_g     = vel_q + {{(VEL_W-1){1'b0}}, grav};
        min_hit   = min_q | (y_q < MIN_Y_U);
        spd_shift = bus.speed >> SPEED_SHIFT;
        vel_start = INIT_S - signed'({{(VEL_W-SPEED_W){1'b0}}, spd_shift});
        vel_air   = vel_g;
        if ((y_q <= MAX_Y_U) && (vel_g < DROP_S))
            vel_air = DROP_S;
        if (!bus.jump && min_hit && (vel_g < DROP_S))
            vel_air = DROP_S;
        // Speed-drop wins over both upward-velocity cuts.
        if (bus.duck)
            vel_air = SDROP_S;
    end

    assign active = (state_q == ST_RUN) || (state_q == ST_JUMP) || (state_q == ST_DUCK);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        acc_d   = acc_q;
        min_d   = min_q;
        anim_d  = anim_q;
        frame_d = frame_of(state_q, anim_q);

        // Crash is the one event that does not wait for the frame tick.
        if (bus.crash && active) begin
            state_d = ST_CRASH;
            if (bus.tick && (state_q == ST_JUMP) && land)
                y_d = GROUND_U;
        end else if (bus.tick) begin
            case (state_q)
                ST_CRASH: begin
                    if (bus.restart) begin
                        state_d = ST_WAIT;
                        y_d     = GROUND_U;
                        vel_d   = '0;
                        acc_d   = '0;
                        min_d   = 1'b0;
                    end
                end
                ST_WAIT, ST_RUN: begin
                    if (bus.jump) begin
                        state_d = ST_JUMP;
                        vel_d   = vel_start;
                        acc_d   = '0;
                        min_d   = 1'b0;
                    end else if ((state_q == ST_RUN) && bus.duck) begin
                        state_d = ST_DUCK;
                        y_d     = DUCK_Y_U;
                    end
                end
                ST_DUCK: begin
                    if (!bus.duck) begin
                        state_d = ST_RUN;
                        y_d     = GROUND_U;
                    end
                end
                ST_JUMP: begin
                    if (land) begin
                        state_d = bus.duck ? ST_DUCK : ST_RUN;
                        y_d     = bus.duck ? DUCK_Y_U : GROUND_U;
                        vel_d   = '0;
                        acc_d   = '0;
                    end else begin
                        y_d   = y_air;
                        vel_d = vel_air;
                        acc_d = acc_air;
                        min_d = min_hit;
                    end
                end
                default: state_d = ST_WAIT;
            endcase
        end

        if (state_d != state_q)
            anim_d = '0;
        else if (bus.tick)
            anim_d = (anim_q >= anim_last(state_q)) ? '0 : anim_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            y_q     <= GROUND_U;
            vel_q   <= '0;
            acc_q   <= '0;
            min_q   <= 1'b0;
            anim_q  <= '0;
            frame_q <= FR_WAIT0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            acc_q   <= acc_d;
            min_q   <= min_d;
            anim_q  <= anim_d;
            frame_q <= frame_d;
        end
    end

    assign bus.x_pos    = POS_W'(START_X);
    assign bus.y_pos    = y_q;
    assign bus.hit_w    = (state_q == ST_DUCK) ? POS_W'(WIDTH_DUCK) : POS_W'(WIDTH);
    assign bus.hit_h    = (state_q == ST_DUCK) ? POS_W'(HEIGHT_DUCK) : POS_W'(HEIGHT);
    assign bus.frame    = frame_q;
    assign bus.state    = state_q;
    assign bus.airborne = (state_q == ST_JUMP);

endmodule

// File: tb/tb_trex_motion.sv
// Self-checking bench for trex_motion: directed scenarios plus randomized play,
// all compared against an integer reference model of the character rules.
module tb_trex_motion;

    localparam int WAITING = 0, RUNNING = 1, JUMPING = 2, DUCKING = 3, CRASHED = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    trex_motion_if #(.POS_W(10), .SPEED_W(4)) bus();

    trex_motion dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: plain integers, animation as an unbounded ticks-in-state count.
    int ms, my, mvel, macc, mmin, mcnt, mfr;

    function automatic int m_frame_of(input int st, input int cnt);
        case (st)
            WAITING: return ((cnt / 30) % 2 == 0) ? 0 : 1;
            RUNNING: return ((cnt / 5) % 2 == 0) ? 2 : 3;
            DUCKING: return ((cnt / 10) % 2 == 0) ? 5 : 6;
            JUMPING: return 4;
            default: return 7;
        endcase
    endfunction

    function automatic void model_reset();
        ms = WAITING; my = 93; mvel = 0; macc = 0; mmin = 0; mcnt = 0; mfr = 0;
    endfunction

    function automatic void model_step();
        int ns;
        int yn;
        ns  = ms;
        mfr = m_frame_of(ms, mcnt);
        if (bus.crash && (ms == RUNNING || ms == JUMPING || ms == DUCKING)) begin
            if (bus.tick && ms == JUMPING && my + mvel >= 93) my = 93;
            ns = CRASHED;
        end else if (bus.tick) begin
            if (ms == CRASHED) begin
                if (bus.restart) begin
                    ns = WAITING; my = 93; mvel = 0; macc = 0; mmin = 0;
                end
            end else if (ms == WAITING || ms == RUNNING) begin
                if (bus.jump) begin
                    ns = JUMPING; mvel = -10 - int'(bus.speed) / 8; macc = 0; mmin = 0;
                end else if (ms == RUNNING && bus.duck) begin
                    ns = DUCKING; my = 115;
                end
            end else if (ms == DUCKING) begin
                if (!bus.duck) begin ns = RUNNING; my = 93; end
            end else begin
                yn = my + mvel;
                if (yn >= 93) begin
                    ns = bus.duck ? DUCKING : RUNNING;
                    my = bus.duck ? 115 : 93;
                    mvel = 0; macc = 0;
                end else begin
                    if (my < 63) mmin = 1;
                    macc += 6;
                    if (macc >= 10) begin macc -= 10; mvel += 1; end
                    if (my <= 30 && mvel < -5) mvel = -5;
                    if (!bus.jump && mmin != 0 && mvel < -5) mvel = -5;
                    if (bus.duck) mvel = 8;
                    my = (yn < 0) ? 0 : yn;
                end
            end
        end
        if (ns != ms) mcnt = 0;
        else if (bus.tick) mcnt++;
        ms = ns;
    endfunction

    function automatic logic [46:0] model_vec();
        logic [9:0] hw, hh;
        hw = (ms == DUCKING) ? 10'd59 : 10'd44;
        hh = (ms == DUCKING) ? 10'd25 : 10'd47;
        return {3'(ms), 10'(my), 3'(mfr), hw, hh, (ms == JUMPING), 10'd50};
    endfunction

    function automatic logic [46:0] dut_vec();
        return {bus.state, bus.y_pos, bus.frame, bus.hit_w, bus.hit_h, bus.airborne, bus.x_pos};
    endfunction

    task automatic cyc(input bit t);
        bus.tick = t;
        @(posedge clk);
        model_step();
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (dut_vec() !== {3'd0, 10'd93, 3'd0, 10'd44, 10'd47, 1'b0, 10'd50}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_vec(),
                     {3'd0, 10'd93, 3'd0, 10'd44, 10'd47, 1'b0, 10'd50});
        end
    endtask

    task automatic test_jump_apex();
        int exp_y[9] = '{82, 71, 61, 51, 42, 34, 26, 19, 14};
        int min_y = 1000;
        bus.speed = 4'd8; bus.jump = 1'b1;
        cyc(1);
        n_chk++;
        if (bus.state !== 3'd2 || bus.y_pos !== 10'd93) begin
            n_fail++;
            $display("FAIL jump_start: state=%0d y=%0d want state=2 y=93", bus.state, bus.y_pos);
        end
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            n_chk++;
            if (bus.y_pos !== 10'(exp_y[i])) begin
                n_fail++;
                $display("FAIL apex_traj[%0d]: y=%0d want %0d", i, bus.y_pos, exp_y[i]);
            end
        end
        for (int i = 0; i < 60 && ms == JUMPING; i++) begin
            cyc(1);
            if (int'(bus.y_pos) < min_y) min_y = int'(bus.y_pos);
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL apex_model t%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_chk++;
        if (bus.state !== 3'd1 || bus.y_pos !== 10'd93 || min_y > 14) begin
            n_fail++;
            $display("FAIL apex_land: state=%0d y=%0d min_y=%0d want 1/93/<=14",
                     bus.state, bus.y_pos, min_y);
        end
        bus.jump = 1'b0;
    endtask

    task automatic test_jump_tap();
        bus.speed = 4'd8; bus.jump = 1'b1;
        cyc(1);
        bus.jump = 1'b0;
        cyc(1);
        cyc(1);
        n_chk++;
        if (bus.y_pos !== 10'd71 || bus.state !== 3'd2) begin
            n_fail++;
            $display("FAIL tap_y: y=%0d state=%0d want 71/2", bus.y_pos, bus.state);
        end
        cyc(1); cyc(1); cyc(1);
        // y 61 -> 51 (vel -10) then release cut to -5 gives 46
        n_chk++;
        if (bus.y_pos !== 10'd46) begin
            n_fail++;
            $display("FAIL tap_release: y=%0d want 46", bus.y_pos);
        end
        for (int i = 0; i < 80 && ms == JUMPING; i++) begin
            cyc(1);
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL tap_model t%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_release_random();
        int hold;
        for (int k = 0; k < 6; k++) begin
            bus.speed = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 10);
            bus.jump = 1'b1;
            cyc(1);
            for (int i = 0; i < 100 && ms == JUMPING; i++) begin
                if (i == hold) bus.jump = 1'b0;
                cyc(($urandom_range(0, 3) != 0));
                n_chk++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++;
                    $display("FAIL release k%0d t%0d: got %h want %h", k, i, dut_vec(), model_vec());
                end
            end
            bus.jump = 1'b0;
            n_chk++;
            if (bus.state !== 3'd1) begin
                n_fail++;
                $display("FAIL release_land k%0d: state=%0d want 1", k, bus.state);
            end
        end
    endtask

    task automatic test_duck_air();
        int y_before;
        bus.speed = 4'd0; bus.jump = 1'b1;
        cyc(1);
        for (int i = 0; i < 5; i++) cyc(1);
        y_before = int'(bus.y_pos);
        bus.duck = 1'b1;
        cyc(1);
        cyc(1);
        n_chk++;
        if (int'(bus.y_pos) - y_before <= 0 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL duck_drop: y=%0d from %0d got %h want %h", bus.y_pos, y_before,
                     dut_vec(), model_vec());
        end
        for (int i = 0; i < 30 && ms == JUMPING; i++) cyc(1);
        n_chk++;
        if (bus.state !== 3'd3 || bus.y_pos !== 10'd115 || bus.hit_w !== 10'd59 ||
            bus.hit_h !== 10'd25) begin
            n_fail++;
            $display("FAIL duck_land: state=%0d y=%0d hw=%0d hh=%0d want 3/115/59/25",
                     bus.state, bus.y_pos, bus.hit_w, bus.hit_h);
        end
    endtask

    task automatic test_duck_run();
        bus.jump = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cyc(1);
            n_chk++;
            if (dut_vec() !== model_vec() || bus.state !== 3'd3) begin
                n_fail++;
                $display("FAIL duck_hold t%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        bus.jump = 1'b0; bus.duck = 1'b0;
        cyc(1);
        n_chk++;
        if (bus.state !== 3'd1 || bus.y_pos !== 10'd93 || bus.hit_w !== 10'd44) begin
            n_fail++;
            $display("FAIL duck_release: state=%0d y=%0d hw=%0d want 1/93/44",
                     bus.state, bus.y_pos, bus.hit_w);
        end
        bus.jump = 1'b1; bus.duck = 1'b1;
        cyc(1);
        n_chk++;
        if (bus.state !== 3'd2) begin
            n_fail++;
            $display("FAIL jump_beats_duck: state=%0d want 2", bus.state);
        end
        for (int i = 0; i < 40 && ms == JUMPING; i++) begin
            cyc(1);
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL jump_duck t%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        bus.jump = 1'b0; bus.duck = 1'b0;
        cyc(1);
    endtask

    task automatic test_no_tick();
        bus.jump = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc(0);
            if (i % 100 == 99) begin
                n_chk++;
                if (dut_vec() !== model_vec() || bus.state !== 3'd1 || bus.y_pos !== 10'd93) begin
                    n_fail++;
                    $display("FAIL no_tick c%0d: got %h want %h", i, dut_vec(), model_vec());
                end
            end
        end
        bus.jump = 1'b0;
    endtask

    task automatic test_crash_restart();
        int y_air;
        bus.speed = 4'd3; bus.jump = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) cyc(1);
        y_air = my;
        bus.crash = 1'b1;
        cyc(0);
        n_chk++;
        if (bus.state !== 3'd4 || int'(bus.y_pos) != y_air) begin
            n_fail++;
            $display("FAIL crash_air: state=%0d y=%0d want 4/%0d", bus.state, bus.y_pos, y_air);
        end
        cyc(0);
        n_chk++;
        if (bus.frame !== 3'd7) begin
            n_fail++;
            $display("FAIL crash_frame: frame=%0d want 7", bus.frame);
        end
        bus.jump = 1'b0; bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
        n_chk++;
        if (bus.state !== 3'd0 || bus.y_pos !== 10'd93) begin
            n_fail++;
            $display("FAIL restart: state=%0d y=%0d want 0/93", bus.state, bus.y_pos);
        end
        for (int i = 0; i < 65; i++) begin
            cyc(1);
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL blink t%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        bus.crash = 1'b0;
    endtask

    task automatic test_crash_landing();
        bit hit = 1'b0;
        bus.speed = 4'd15; bus.jump = 1'b1;
        cyc(1);
        bus.jump = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (ms == JUMPING && my + mvel >= 93) begin
                bus.crash = 1'b1;
                hit = 1'b1;
            end
            cyc(1);
        end
        n_chk++;
        if (!hit || bus.state !== 3'd4 || bus.y_pos !== 10'd93) begin
            n_fail++;
            $display("FAIL crash_landing: seen=%0d state=%0d y=%0d want 1/4/93",
                     hit, bus.state, bus.y_pos);
        end
        bus.crash = 1'b0; bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
    endtask

    task automatic test_reset_midjump();
        bus.speed = 4'd0; bus.jump = 1'b1;
        cyc(1);
        cyc(1); cyc(1); cyc(1);
        n_chk++;
        if (bus.state !== 3'd2 || bus.y_pos === 10'd93) begin
            n_fail++;
            $display("FAIL pre_reset: state=%0d y=%0d want 2/not 93", bus.state, bus.y_pos);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (bus.y_pos !== 10'd93 || bus.state !== 3'd0 || bus.airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midjump: y=%0d state=%0d air=%0d want 93/0/0",
                     bus.y_pos, bus.state, bus.airborne);
        end
        #1 rst_n = 1'b1;
        bus.jump = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.jump = ~bus.jump;
            if ($urandom_range(0, 11) == 0) bus.duck = ~bus.duck;
            if ($urandom_range(0, 31) == 0) bus.speed = 4'($urandom_range(0, 15));
            bus.crash = ($urandom_range(0, 199) == 0);
            bus.restart = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 2) == 0));
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        bus.crash = 1'b0; bus.restart = 1'b0; bus.jump = 1'b0; bus.duck = 1'b0;
    endtask

    initial begin
        bus.tick = 1'b0; bus.speed = '0; bus.jump = 1'b0; bus.duck = 1'b0;
        bus.crash = 1'b0; bus.restart = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_jump_apex();
        test_jump_tap();
        test_release_random();
        test_duck_air();
        test_duck_run();
        test_no_tick();
        test_crash_restart();
        test_crash_landing();
        test_reset_midjump();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
